mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Sequential instruction encoder and program loader for the single-cycle MIPS datapath. It performs the inverse of the opcode decode. It accepts instruction requests as separate fields (instruction kind, register numbers, shamt, funct, immediate) over a valid/ready handshake. It packs each request into a 32-bit MIPS word and writes it into consecutive words of instruction memory. The bench and the boot logic use it to build programs for the supported subset: R-type, ADDI, ORI and LUI.

## Interface
- ADDR_WIDTH, 6, word-address width of the instruction memory; capacity = 2^ADDR_WIDTH words.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous program restart: write pointer returns to 0.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- op_kind  input  2  0 = R-type, 1 = ADDI, 2 = ORI, 3 = LUI.
- rs, rt, rd, shamt  input  5 each  instruction fields.
- funct  input  6  R-type function field.
- imm  input  16  immediate field.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_WIDTH+1  number of words written since reset or clear.
- full  output  1  memory full; no further requests accepted.

## Operation
- States: IDLE, ENC, WR, FULL. Reset and clear both force IDLE.
- in_ready = 1 only in IDLE. It is combinational from state.
- IDLE: a request is accepted when in_valid && in_ready at an edge. On acceptance, all input fields are captured into holding registers and the state moves to ENC. Inputs are don't-care at all other times.
- ENC: the encoded word is formed from the captured fields and registered into mem_wdata. mem_addr is loaded with the write pointer. Next state is WR.
- WR: mem_we = 1 for exactly this one cycle. At the end of WR:
  - the write pointer and count increment;
  - if count reaches 2^ADDR_WIDTH, next state is FULL; otherwise IDLE.
- FULL: in_ready = 0 and full = 1. The block stays here until clear or reset.
- Encoding (op_kind):
  - 0 → {6'h00, rs, rt, rd, shamt, funct}
  - 1 → {6'h08, rs, rt, imm}
  - 2 → {6'h0D, rs, rt, imm}
  - 3 → {6'h0F, 5'd0, rt, imm}. The rs input is ignored for LUI; rd, shamt and funct are ignored for all I-type kinds.
- clear behaviour:
  - In ENC: the pending write is cancelled and mem_we stays 0.
  - In WR: the write already on the bus completes, then the pointer and count go to 0.
  - In any state: next state is IDLE and full = 0.
- Priority: reset > clear > handshake.
- The pointer never wraps. Overwriting word 0 requires clear.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, state IDLE, so in_ready is 1 from the first post-reset cycle.
- Latency:
  - Acceptance at edge E0.
  - mem_wdata and mem_addr are valid from E1.
  - mem_we is high during the cycle E1–E2; memory samples the write at E2.
  - count updates at E2; in_ready is high again after E2.
- Throughput is 1 instruction per 3 cycles. With in_valid held high, a new request is accepted every third edge and none is duplicated.
- mem_wdata and mem_addr hold their last values outside WR. Only mem_we qualifies a write.
- full rises at the same edge that count reaches 2^ADDR_WIDTH.
- Reset asserted mid-ENC or mid-WR: mem_we is 0 from the next cycle and all registers return to their reset values.

## Test plan
- ADDI: op_kind 1, rs 0, rt 8, imm 0x0005 → single mem_we pulse at addr 0, wdata 0x20080005, count 1.
- R-type add: op_kind 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20 → wdata 0x012A4020 at the next address. ORI with rs 1, rt 1, imm 0x0024 → 0x34210024.
- LUI: op_kind 3, rs 31, rt 1, imm 0x1001 → wdata 0x3C011001 (rs forced 0).
- Streaming: in_valid held high for 4 requests → mem_we pulses exactly every 3 cycles at addrs 0,1,2,3. in_ready is high only in IDLE cycles.
- Fill: ADDR_WIDTH 2, 4 requests → full = 1, count = 4, in_ready = 0. A 5th held request produces no write. Then clear → count 0, full 0, and the next write lands at addr 0.
- Abort: clear during ENC → no mem_we, count unchanged at 0. Reset during WR → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Packs field-wise MIPS instruction requests (R-type, ADDI, ORI, LUI) into 32-bit words
// and writes them to consecutive instruction-memory addresses, one word per three cycles.
//
// state | meaning
// IDLE  | ready for a request; in_ready high
// ENC   | encode captured fields into mem_wdata, load mem_addr
// WR    | mem_we high for one cycle; pointer/count advance at its end
// FULL  | memory full; waits for clear or reset
module mips_instr_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op_kind,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2,
        FULL = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state;
    logic [1:0]          kindHold;
    logic [4:0]          rsHold;
    logic [4:0]          rtHold;
    logic [4:0]          rdHold;
    logic [4:0]          shamtHold;
    logic [5:0]          functHold;
    logic [15:0]         immHold;
    logic [31:0]         encWord;
    logic [ADDR_WIDTH:0] countNext;

    assign in_ready  = (state == IDLE);
    assign countNext = count + 1'b1;

    // The write pointer is the low bits of count; it never wraps because FULL blocks first.
    always_comb begin
        encWord = 32'h0;
        unique case (kindHold)
            2'd0: encWord = {6'h00, rsHold, rtHold, rdHold, shamtHold, functHold};
            2'd1: encWord = {6'h08, rsHold, rtHold, immHold};
            2'd2: encWord = {6'h0D, rsHold, rtHold, immHold};
            2'd3: encWord = {6'h0F, 5'd0, rtHold, immHold};
            default: encWord = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            count     <= '0;
            full      <= 1'b0;
            kindHold  <= 2'd0;
            rsHold    <= 5'd0;
            rtHold    <= 5'd0;
            rdHold    <= 5'd0;
            shamtHold <= 5'd0;
            functHold <= 6'd0;
            immHold   <= 16'h0;
        end else if (clear) begin
            // A write already strobed in WR is sampled at this edge; an ENC write is dropped.
            state  <= IDLE;
            mem_we <= 1'b0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        kindHold  <= op_kind;
                        rsHold    <= rs;
                        rtHold    <= rt;
                        rdHold    <= rd;
                        shamtHold <= shamt;
                        functHold <= funct;
                        immHold   <= imm;
                        state     <= ENC;
                    end
                end
                ENC: begin
                    mem_wdata <= encWord;
                    mem_addr  <= count[ADDR_WIDTH-1:0];
                    mem_we    <= 1'b1;
                    state     <= WR;
                end
                WR: begin
                    mem_we <= 1'b0;
                    count  <= countNext;
                    if (countNext == CAPACITY) begin
                        full  <= 1'b1;
                        state <= FULL;
                    end else begin
                        state <= IDLE;
                    end
                end
                FULL: begin
                    full <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with a 4-word memory: encodings, streaming,
// fill/full, clear in each state, and reset in the middle of a write.
module tb_mips_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op_kind;
    logic [4:0]    rs, rt, rd, shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          full;

    int nAsserts = 0;
    int nFails   = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_kind(op_kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setFields(input logic [1:0] k, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] d, input logic [5:0] f,
                             input logic [15:0] im);
        op_kind = k; rs = a; rt = b; rd = c; shamt = d; funct = f; imm = im;
    endtask

    // Full request: accept, encode, write; checks each of the three cycles.
    task automatic sendReq(input string tag, input logic [1:0] k, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] c, input logic [4:0] d,
                           input logic [5:0] f, input logic [15:0] im, input int expAddr,
                           input logic [31:0] expWord, input int expCount, input logic expFull);
        setFields(k, a, b, c, d, f, im);
        in_valid = 1'b1;
        chk({tag, ".ready_idle"}, in_ready, 1);
        tick;
        in_valid = 1'b0;
        setFields(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);
        chk({tag, ".enc_we"}, mem_we, 0);
        chk({tag, ".enc_ready"}, in_ready, 0);
        tick;
        chk({tag, ".wr_we"}, mem_we, 1);
        chk({tag, ".wr_addr"}, mem_addr, expAddr);
        chk({tag, ".wr_data"}, mem_wdata, expWord);
        chk({tag, ".wr_count"}, count, expCount - 1);
        tick;
        chk({tag, ".post_we"}, mem_we, 0);
        chk({tag, ".post_count"}, count, expCount);
        chk({tag, ".post_full"}, full, expFull);
        chk({tag, ".post_ready"}, in_ready, !expFull);
    endtask

    initial begin
        int phase;
        int idx;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        setFields(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);
        tick; tick;
        reset = 1'b0;
        tick;
        chk("rst.we", mem_we, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.data", mem_wdata, 0);
        chk("rst.count", count, 0);
        chk("rst.full", full, 0);
        chk("rst.ready", in_ready, 1);

        // rd/shamt/funct driven to junk on I-types; rs junk on LUI
        sendReq("addi", 2'd1, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0005, 0, 32'h20080005, 1, 1'b0);
        sendReq("add", 2'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'hFFFF, 1, 32'h012A4020, 2, 1'b0);
        sendReq("ori", 2'd2, 5'd1, 5'd1, 5'd7, 5'd3, 6'h11, 16'h0024, 2, 32'h34210024, 3, 1'b0);
        sendReq("lui", 2'd3, 5'd31, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1001, 3, 32'h3C011001, 4, 1'b1);

        setFields(2'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234);
        in_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick;
            chk("full.no_we", mem_we, 0);
            chk("full.ready", in_ready, 0);
        end
        chk("full.count_hold", count, 4);
        in_valid = 1'b0;

        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clr.count", count, 0);
        chk("clr.full", full, 0);
        chk("clr.ready", in_ready, 1);

        // Streaming: ADDI rs0, rt=i+1, imm=i*0x111 with in_valid held high
        setFields(2'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0000);
        in_valid = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick;
            phase = (n - 1) % 3;
            idx   = (n - 1) / 3;
            chk("strm.we", mem_we, (phase == 1));
            chk("strm.ready", in_ready, (phase == 2 && idx < 3));
            if (phase == 1) begin
                chk("strm.addr", mem_addr, idx);
                chk("strm.data", mem_wdata,
                    32'h20000000 | (32'(idx + 1) << 16) | (32'(idx) * 32'h111));
            end
            if (phase == 2 && idx < 3)
                setFields(2'd1, 5'd0, 5'(idx + 2), 5'd0, 5'd0, 6'd0, 16'((idx + 1) * 'h111));
        end
        chk("strm.count", count, 4);
        chk("strm.full", full, 1);
        tick; tick; tick;
        chk("strm.no_dup_we", mem_we, 0);
        chk("strm.no_dup_count", count, 4);
        in_valid = 1'b0;

        clear = 1'b1;
        tick;
        clear = 1'b0;

        // Clear during ENC cancels the write
        setFields(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("abort.we", mem_we, 0);
        chk("abort.count", count, 0);
        chk("abort.ready", in_ready, 1);
        tick;
        chk("abort.we_later", mem_we, 0);
        chk("abort.count_later", count, 0);

        // Clear during WR: write completes on the bus, then count returns to 0
        setFields(2'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0024);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk("clrwr.we", mem_we, 1);
        chk("clrwr.addr", mem_addr, 0);
        chk("clrwr.data", mem_wdata, 32'h34210024);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clrwr.we_after", mem_we, 0);
        chk("clrwr.count", count, 0);
        chk("clrwr.full", full, 0);

        // sll $8,$9,4 lands at address 0 after the clear
        sendReq("sll", 2'd0, 5'd0, 5'd9, 5'd8, 5'd4, 6'h00, 16'h0, 0, 32'h00094100, 1, 1'b0);

        // Reset during WR
        setFields(2'd3, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'hABCD);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk("rstwr.we", mem_we, 1);
        chk("rstwr.addr", mem_addr, 1);
        chk("rstwr.data", mem_wdata, 32'h3C02ABCD);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstwr.we_after", mem_we, 0);
        chk("rstwr.addr_after", mem_addr, 0);
        chk("rstwr.data_after", mem_wdata, 0);
        chk("rstwr.count_after", count, 0);
        chk("rstwr.full_after", full, 0);
        chk("rstwr.ready_after", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
